// File: rtl/pipelined_control_unit.sv
// RV32I(+M) decode stage with ID/EX register, illegal-instruction detection
// and a mul/div busy sequencer that back-pressures fetch for MD_LAT cycles.
module pipelined_control_unit #(
  parameter bit M_EXT      = 1'b1,
  parameter int MD_LAT     = 4,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [6:0]            opcode,
  input  logic [2:0]            fun3,
  input  logic [6:0]            fun7,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  ex_valid,
  output logic                  reg_write,
  output logic [2:0]            imm_sel,
  output logic                  operand_a,
  output logic                  operand_b,
  output logic [1:0]            mem_to_reg,
  output logic                  load,
  output logic                  store,
  output logic                  branch,
  output logic                  jalr_out,
  output logic                  mem_en,
  output logic                  next_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic                  md_start
);
  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MD = 7'b0000001;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10;

  typedef enum logic {IDLE, MD_WAIT} state_t;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_sel;
    logic       operand_a;
    logic       operand_b;
    logic [1:0] mem_to_reg;
    logic       load;
    logic       store;
    logic       branch;
    logic       jalr_out;
    logic       next_sel;
    logic [4:0] alu;
    logic       illegal;
    logic       is_md;
  } ctrl_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ctrl_t            dec;
  logic             legal;
  logic             accept;

  // base ALU op for the fun3 field (fun7 variants handled by the caller)
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign in_ready = (state == IDLE) && !stall;
  assign accept   = instr_valid && in_ready;

  // combinational decode; an illegal encoding collapses to a bare illegal flag
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (fun7 == F7_BASE)
          dec.alu = alu_base(fun3);
        else if (fun7 == F7_ALT && fun3 == 3'b000)
          dec.alu = ALU_SUB;
        else if (fun7 == F7_ALT && fun3 == 3'b101)
          dec.alu = ALU_SRA;
        else if (fun7 == F7_MD && M_EXT) begin
          dec.alu   = {2'b10, fun3};
          dec.is_md = 1'b1;
        end else
          legal = 1'b0;
      end
      OP_I: begin
        // fun7 is immediate bits except on shifts, where it selects SRAI
        dec.reg_write = 1'b1;
        dec.operand_b = 1'b1;
        dec.alu       = alu_base(fun3);
        if (fun3 == 3'b001 && fun7 != F7_BASE) legal = 1'b0;
        if (fun3 == 3'b101) begin
          if (fun7 == F7_ALT) dec.alu = ALU_SRA;
          else if (fun7 != F7_BASE) legal = 1'b0;
        end
      end
      OP_LD: begin
        dec.reg_write  = 1'b1;
        dec.operand_b  = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.load       = 1'b1;
      end
      OP_ST: begin
        dec.imm_sel   = 3'b001;
        dec.operand_b = 1'b1;
        dec.store     = 1'b1;
      end
      OP_BR: begin
        dec.imm_sel   = 3'b010;
        dec.operand_a = 1'b1;
        dec.operand_b = 1'b1;
        dec.branch    = 1'b1;
        dec.alu       = ALU_SUB;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_sel    = 3'b100;
        dec.operand_a  = 1'b1;
        dec.operand_b  = 1'b1;
        dec.mem_to_reg = 2'b10;
        dec.next_sel   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.operand_b  = 1'b1;
        dec.mem_to_reg = 2'b10;
        dec.jalr_out   = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.imm_sel   = 3'b011;
        dec.operand_b = 1'b1;
        dec.alu       = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm_sel   = 3'b011;
        dec.operand_a = 1'b1;
        dec.operand_b = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // mul/div sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // busy countdown runs regardless of stall; flush aborts it
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (accept && dec.is_md) begin
          state_n = MD_WAIT;
          cnt_n   = CNT_W'(MD_LAT - 1);
        end
        MD_WAIT: if (cnt == '0) state_n = IDLE;
                 else cnt_n = cnt - 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  // ID/EX register: flush or an unstalled empty slot kills the live bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      reg_write   <= 1'b0;
      imm_sel     <= '0;
      operand_a   <= 1'b0;
      operand_b   <= 1'b0;
      mem_to_reg  <= '0;
      load        <= 1'b0;
      store       <= 1'b0;
      branch      <= 1'b0;
      jalr_out    <= 1'b0;
      mem_en      <= 1'b0;
      next_sel    <= 1'b0;
      alu_control <= '0;
      illegal     <= 1'b0;
      md_start    <= 1'b0;
    end else if (flush || (!stall && !accept)) begin
      ex_valid  <= 1'b0;
      reg_write <= 1'b0;
      load      <= 1'b0;
      store     <= 1'b0;
      branch    <= 1'b0;
      jalr_out  <= 1'b0;
      mem_en    <= 1'b0;
      next_sel  <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
    end else if (stall) begin
      md_start <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      reg_write   <= dec.reg_write;
      imm_sel     <= dec.imm_sel;
      operand_a   <= dec.operand_a;
      operand_b   <= dec.operand_b;
      mem_to_reg  <= dec.mem_to_reg;
      load        <= dec.load;
      store       <= dec.store;
      branch      <= dec.branch;
      jalr_out    <= dec.jalr_out;
      mem_en      <= dec.load | dec.store;
      next_sel    <= dec.next_sel;
      alu_control <= dec.alu[ALU_CTRL_W-1:0];
      illegal     <= dec.illegal;
      md_start    <= dec.is_md;
    end
  end
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: two DUTs (with and without RV32M) share stimulus; a
// behavioural model predicts each cycle's outputs, a monitor compares them.
module tb_pipelined_control_unit;
  typedef struct packed {
    logic       in_ready;
    logic       ex_valid;
    logic       reg_write;
    logic [2:0] imm_sel;
    logic       operand_a;
    logic       operand_b;
    logic [1:0] mem_to_reg;
    logic       load;
    logic       store;
    logic       branch;
    logic       jalr_out;
    logic       mem_en;
    logic       next_sel;
    logic [4:0] alu;
    logic       illegal;
    logic       md_start;
  } obs_t;

  logic clk = 1'b0, rst = 1'b0;
  logic instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [6:0] opcode = '0, fun7 = '0;
  logic [2:0] fun3 = '0;

  logic ir1, ev1, rw1, oa1, ob1, ld1, st1, br1, jr1, me1, ns1, il1, ms1;
  logic [2:0] is1;
  logic [1:0] mr1;
  logic [4:0] al1;
  logic ir0, ev0, rw0, oa0, ob0, ld0, st0, br0, jr0, me0, ns0, il0, ms0;
  logic [2:0] is0;
  logic [1:0] mr0;
  logic [3:0] al0;

  obs_t obs1, obs0;
  obs_t q1[$], q0[$];
  obs_t mexp[2];
  int   busy[2];
  int   n_cmp = 0, n_bad = 0;
  int   lat[2] = '{1, 4};
  int   alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  always #5 clk = ~clk;

  pipelined_control_unit #(.M_EXT(1'b1), .MD_LAT(4), .ALU_CTRL_W(5)) u_m (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .fun3(fun3),
    .fun7(fun7), .stall(stall), .flush(flush), .in_ready(ir1), .ex_valid(ev1),
    .reg_write(rw1), .imm_sel(is1), .operand_a(oa1), .operand_b(ob1), .mem_to_reg(mr1),
    .load(ld1), .store(st1), .branch(br1), .jalr_out(jr1), .mem_en(me1), .next_sel(ns1),
    .alu_control(al1), .illegal(il1), .md_start(ms1));

  pipelined_control_unit #(.M_EXT(1'b0), .MD_LAT(1), .ALU_CTRL_W(4)) u_i (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .fun3(fun3),
    .fun7(fun7), .stall(stall), .flush(flush), .in_ready(ir0), .ex_valid(ev0),
    .reg_write(rw0), .imm_sel(is0), .operand_a(oa0), .operand_b(ob0), .mem_to_reg(mr0),
    .load(ld0), .store(st0), .branch(br0), .jalr_out(jr0), .mem_en(me0), .next_sel(ns0),
    .alu_control(al0), .illegal(il0), .md_start(ms0));

  assign obs1 = {ir1, ev1, rw1, is1, oa1, ob1, mr1, ld1, st1, br1, jr1, me1, ns1, al1, il1, ms1};
  assign obs0 = {ir0, ev0, rw0, is0, oa0, ob0, mr0, ld0, st0, br0, jr0, me0, ns0, 1'b0, al0, il0, ms0};

  // reference decode straight from the instruction-class table
  function automatic obs_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input bit mext, output bit is_md);
    obs_t d = '0;
    bit ok = 1'b1;
    is_md = 1'b0;
    d.operand_b = 1'b1;
    d.reg_write = 1'b1;
    case (op)
      7'b0110011: begin
        d.operand_b = 1'b0;
        if (f7 == 7'h00) d.alu = 5'(alu_tab[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 5'd7;
        else if (f7 == 7'h01 && mext) begin d.alu = 5'(16 + int'(f3)); is_md = 1'b1; end
        else ok = 1'b0;
      end
      7'b0010011: begin
        d.alu = 5'(alu_tab[f3]);
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) d.alu = 5'd7;
        end
      end
      7'b0000011: begin d.mem_to_reg = 2'b01; d.load = 1'b1; d.mem_en = 1'b1; end
      7'b0100011: begin d.reg_write = 1'b0; d.imm_sel = 3'b001; d.store = 1'b1; d.mem_en = 1'b1; end
      7'b1100011: begin d.reg_write = 1'b0; d.imm_sel = 3'b010; d.operand_a = 1'b1; d.branch = 1'b1; d.alu = 5'd1; end
      7'b1101111: begin d.imm_sel = 3'b100; d.operand_a = 1'b1; d.mem_to_reg = 2'b10; d.next_sel = 1'b1; end
      7'b1100111: begin d.mem_to_reg = 2'b10; d.jalr_out = 1'b1; end
      7'b0110111: begin d.imm_sel = 3'b011; d.alu = 5'd10; end
      7'b0010111: begin d.imm_sel = 3'b011; d.operand_a = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin d = '0; d.illegal = 1'b1; is_md = 1'b0; end
    return d;
  endfunction

  function automatic obs_t live_mask();
    obs_t m = '0;
    m.in_ready = 1'b1; m.ex_valid = 1'b1; m.reg_write = 1'b1; m.load = 1'b1;
    m.store = 1'b1; m.branch = 1'b1; m.jalr_out = 1'b1; m.mem_en = 1'b1;
    m.next_sel = 1'b1; m.md_start = 1'b1;
    return m;
  endfunction

  // drive one cycle of stimulus and predict both DUTs' state after the edge
  task automatic step(input bit r, input bit iv, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input bit st, input bit fl);
    @(negedge clk);
    rst = r; instr_valid = iv; opcode = op; fun3 = f3; fun7 = f7; stall = st; flush = fl;
    for (int k = 0; k < 2; k++) begin
      obs_t e, d;
      bit mdk, acc;
      e   = mexp[k];
      acc = iv && (busy[k] == 0) && !st;
      d   = ref_decode(op, f3, f7, k == 1, mdk);
      if (!r) begin
        e = '0; busy[k] = 0;
      end else if (fl || (!st && !acc)) begin
        e.ex_valid = 0; e.reg_write = 0; e.load = 0; e.store = 0; e.branch = 0;
        e.jalr_out = 0; e.mem_en = 0; e.next_sel = 0; e.illegal = 0; e.md_start = 0;
        busy[k] = fl ? 0 : (busy[k] > 0 ? busy[k] - 1 : 0);
      end else begin
        if (busy[k] > 0) busy[k]--;
        if (st) e.md_start = 1'b0;
        else begin
          e = d; e.ex_valid = 1'b1; e.md_start = mdk;
          if (mdk) busy[k] = lat[k];
        end
      end
      e.in_ready = (busy[k] == 0) && !st;
      mexp[k] = e;
      if (k == 1) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic cmp(input string nm, input obs_t got, input obs_t e);
    obs_t m;
    if (e.ex_valid) m = '1; else m = live_mask();
    n_cmp++;
    if (((got ^ e) & m) != '0) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got & m, e & m);
    end
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  // monitor: every post-edge output set is a response to the previous cycle
  initial begin
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("m_ext_dut", obs1, e); end
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("base_dut", obs0, e); end
    end
  end

  initial begin
    mexp[0] = '0; mexp[1] = '0; busy[0] = 0; busy[1] = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_in_ready", int'(ir1), 1);
    chk("reset_ex_valid", int'(ev1), 0);
    chk("reset_enables", int'({rw1, me1, ld1, st1, br1, jr1, ns1, ms1, il1}), 0);
    chk("reset_base_dut", int'({ev0, rw0, me0, il0}), 0);

    step(1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
    step(1, 1, 7'b0110011, 3'd0, 7'h00, 0, 0);   // ADD
    step(1, 1, 7'b0110011, 3'd0, 7'h20, 0, 0);   // SUB
    step(1, 1, 7'b0000011, 3'd2, 7'h00, 0, 0);   // LW
    step(1, 1, 7'b1101111, 3'd0, 7'h00, 0, 0);   // JAL
    step(1, 1, 7'b0110011, 3'd4, 7'h01, 0, 0);   // DIV
    @(posedge clk); #2;
    chk("div_alu", int'(al1), 20);
    chk("div_md_start", int'(ms1), 1);
    chk("div_base_illegal", int'({il0, rw0, ev0}), 3'b101);
    for (int i = 0; i < 5; i++) step(1, 1, 7'b0110011, 3'd0, 7'h00, 0, 0);
    step(1, 1, 7'b1111111, 3'd0, 7'h00, 0, 0);   // illegal opcode
    step(1, 1, 7'b0110011, 3'd0, 7'h00, 0, 1);   // flush beats accept
    step(1, 1, 7'b1100011, 3'd0, 7'h00, 0, 0);   // BEQ
    for (int i = 0; i < 3; i++) step(1, 1, 7'b0010011, 3'd0, 7'h00, 1, 0);
    step(1, 1, 7'b0110011, 3'd4, 7'h01, 0, 0);   // DIV then flush mid-wait
    step(1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
    step(1, 0, 7'h00, 3'd0, 7'h00, 0, 1);
    step(1, 1, 7'b0110111, 3'd0, 7'h00, 0, 0);   // LUI accepted right after
    step(1, 1, 7'b0110011, 3'd1, 7'h01, 0, 0);   // MULH then reset mid-wait
    step(1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
    step(0, 0, 7'h00, 3'd0, 7'h00, 0, 0);
    step(1, 1, 7'b0010011, 3'd5, 7'h20, 0, 0);   // SRAI
    step(1, 1, 7'b0010111, 3'd0, 7'h00, 0, 0);   // AUIPC

    for (int i = 0; i < 600; i++) begin
      int oi, fi;
      logic [6:0] op, f7;
      oi = int'($urandom_range(0, 9));
      if (oi == 9) op = 7'($urandom); else op = ops[oi];
      fi = int'($urandom_range(0, 3));
      f7 = (fi == 0) ? 7'h00 : (fi == 1) ? 7'h20 : (fi == 2) ? 7'h01 : 7'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), op,
           3'($urandom), f7, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
    end

    step(1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("queues_drained", q1.size() + q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
